// File: rtl/data_sram_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : data_sram_ctrl_pkg
// Brief    : Shared state encodings and strobe levels for the data SRAM port.
// Revision : 1.0
// =============================================================================
package data_sram_ctrl_pkg;

    localparam logic [2:0] SramIdle   = 3'd0;
    localparam logic [2:0] SramRead   = 3'd1;
    localparam logic [2:0] SramWsetup = 3'd2;
    localparam logic [2:0] SramWpulse = 3'd3;
    localparam logic [2:0] SramWhold  = 3'd4;
    localparam logic [2:0] SramDone   = 3'd5;

    localparam logic ChipEnable   = 1'b0;
    localparam logic ChipDisable  = 1'b1;
    localparam logic WriteEnable  = 1'b0;
    localparam logic WriteDisable = 1'b1;
    localparam logic RstEnableN   = 1'b0;

    function automatic logic is_busy(input logic [2:0] st);
        return st inside {SramRead, SramWsetup, SramWpulse, SramWhold};
    endfunction

    function automatic logic is_write(input logic [2:0] st);
        return st inside {SramWsetup, SramWpulse, SramWhold};
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : data_sram_ctrl_if
// Brief    : Memory-stage data request bus between pipeline and SRAM controller.
// Revision : 1.0
// =============================================================================
interface data_sram_ctrl_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        hold_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, hold_i,
        input  mem_data_o, stallreq_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, hold_i,
        output mem_data_o, stallreq_o
    );
endinterface
`default_nettype wire

// File: rtl/data_sram_ctrl_wait_counter.sv
`default_nettype none
// =============================================================================
// Module   : sram_wait_counter
// Brief    : Loadable wait counter with a terminal flag for timed SRAM states.
// Revision : 1.0
// =============================================================================
module sram_wait_counter
    import data_sram_ctrl_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] last,
    output logic                  term
);
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst == RstEnableN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign term = en && (cnt == last);
endmodule
`default_nettype wire

// File: rtl/data_sram_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : data_sram_ctrl
// Brief    : Multi-cycle responder for the memory-stage data port on async SRAM.
// Revision : 1.0
// =============================================================================
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    data_sram_ctrl_if.slave        mem,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [31:0]            ram_data_o,
    output logic                   ram_data_oe_o,
    input  wire logic [31:0]       ram_data_i,
    output logic                   ram_ce_n_o,
    output logic                   ram_oe_n_o,
    output logic                   ram_we_n_o,
    output logic [3:0]             ram_be_n_o
);
    localparam int MaxWait = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
    localparam int CntW    = $clog2(MaxWait) + 1;

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [3:0]      sel_q;
    logic [3:0]      sel_nx;
    logic [31:0]     rdata_q;
    logic            accept;
    logic            cnt_load;
    logic            cnt_term;
    logic [CntW-1:0] cnt_last;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{mem.mem_addr_i[31:ADDR_W+2], mem.mem_addr_i[1:0]};

    assign accept   = (state == SramIdle) && mem.mem_ce_i;
    assign sel_nx   = accept ? mem.mem_sel_i : sel_q;
    assign cnt_load = !((state == SramRead) || (state == SramWpulse));
    assign cnt_last = (state == SramRead) ? CntW'(READ_WAIT - 1) : CntW'(WRITE_PULSE - 1);

    sram_wait_counter #(
        .WIDTH (CntW)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (!cnt_load),
        .last (cnt_last),
        .term (cnt_term)
    );

    always_comb begin
        state_nx = state;
        case (state)
            SramIdle: begin
                if (mem.mem_ce_i) begin
                    if (!mem.mem_we_i)            state_nx = SramRead;
                    else if (mem.mem_sel_i != '0) state_nx = SramWsetup;
                    else                          state_nx = SramDone;
                end
            end
            SramRead:   if (cnt_term) state_nx = SramDone;
            SramWsetup: state_nx = SramWpulse;
            SramWpulse: if (cnt_term) state_nx = SramWhold;
            SramWhold:  state_nx = SramDone;
            SramDone:   if (!mem.hold_i) state_nx = SramIdle;
            default:    state_nx = SramIdle;
        endcase
    end

    // Strobes are registered from the next state so the SRAM pins never glitch.
    always_ff @(posedge clk) begin
        if (rst == RstEnableN) begin
            state         <= SramIdle;
            sel_q         <= '0;
            rdata_q       <= '0;
            ram_addr_o    <= '0;
            ram_data_o    <= '0;
            ram_data_oe_o <= 1'b0;
            ram_ce_n_o    <= ChipDisable;
            ram_oe_n_o    <= 1'b1;
            ram_we_n_o    <= WriteDisable;
            ram_be_n_o    <= 4'b1111;
        end else begin
            state <= state_nx;
            if (accept) begin
                sel_q      <= mem.mem_sel_i;
                ram_addr_o <= mem.mem_addr_i[ADDR_W+1:2];
                ram_data_o <= mem.mem_data_i;
            end
            if ((state == SramRead) && cnt_term) begin
                rdata_q <= ram_data_i;
            end
            ram_ce_n_o    <= is_busy(state_nx) ? ChipEnable : ChipDisable;
            ram_oe_n_o    <= (state_nx == SramRead) ? 1'b0 : 1'b1;
            ram_we_n_o    <= (state_nx == SramWpulse) ? WriteEnable : WriteDisable;
            ram_data_oe_o <= is_write(state_nx);
            if (state_nx == SramRead)     ram_be_n_o <= 4'b0000;
            else if (is_write(state_nx))  ram_be_n_o <= ~sel_nx;
            else                          ram_be_n_o <= 4'b1111;
        end
    end

    assign mem.mem_data_o = rdata_q;
    assign mem.stallreq_o = accept || is_busy(state);
endmodule
`default_nettype wire

// File: tb/tb_data_sram_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_data_sram_ctrl
// Brief    : Directed-vector bench for data_sram_ctrl with a behavioural SRAM.
// Revision : 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_data_sram_ctrl;
    localparam int ADDR_W      = 20;
    localparam int READ_WAIT   = 2;
    localparam int WRITE_PULSE = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_sram_ctrl_if bus ();

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_data_oe;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic [3:0]        ram_be_n;

    data_sram_ctrl #(
        .ADDR_W      (ADDR_W),
        .READ_WAIT   (READ_WAIT),
        .WRITE_PULSE (WRITE_PULSE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (bus.slave),
        .ram_addr_o    (ram_addr),
        .ram_data_o    (ram_wdata),
        .ram_data_oe_o (ram_data_oe),
        .ram_data_i    (ram_rdata),
        .ram_ce_n_o    (ram_ce_n),
        .ram_oe_n_o    (ram_oe_n),
        .ram_we_n_o    (ram_we_n),
        .ram_be_n_o    (ram_be_n)
    );

    logic [31:0] sram    [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [0:255];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          viol     = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h10) return 32'hDEADBEEF;
        if (i == 'h20) return 32'h11223344;
        if (i == 'h01) return 32'hCAFEF00D;
        return 32'hA5A50000 ^ (32'(i) * 32'h01010101);
    endfunction

    // SRAM model: byte-lane write while ce_n and we_n are both low at an edge.
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (!ram_ce_n && !ram_we_n) begin
                for (int b = 0; b < 4; b++)
                    if (!ram_be_n[b]) sram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
            end
        end
    end

    assign ram_rdata = sram[ram_addr];

    always @(negedge clk) begin
        if (rst) begin
            if (!ram_oe_n && ram_data_oe) viol++;
            if (!ram_we_n && !ram_oe_n)   viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, output int stall, output int oe_cyc,
                          output int we_cyc, output int ce_cyc,
                          output logic [ADDR_W-1:0] addr_seen, output logic [3:0] be_seen);
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = we;
        bus.mem_sel_i  = sel;
        bus.mem_addr_i = addr;
        bus.mem_data_i = data;
        #1;
        stall = 0; oe_cyc = 0; we_cyc = 0; ce_cyc = 0;
        addr_seen = '0; be_seen = 4'hF;
        while (bus.stallreq_o && stall < 64) begin
            stall++;
            tick();
            if (!ram_ce_n) ce_cyc++;
            if (!ram_oe_n) begin oe_cyc++; addr_seen = ram_addr; end
            if (!ram_we_n) begin we_cyc++; be_seen = ram_be_n; end
        end
        if (stall >= 64) check("timeout", 32'(stall), 32'd0);
    endtask

    task automatic end_req();
        bus.mem_ce_i = 1'b0;
        bus.hold_i   = 1'b0;
        tick();
    endtask

    int                stall, oe_cyc, we_cyc, ce_cyc;
    logic [ADDR_W-1:0] aseen;
    logic [3:0]        beseen;
    logic [31:0]       last_rd;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_sel_i = '0;
        bus.mem_addr_i = '0; bus.mem_data_i = '0; bus.hold_i = 1'b0;
        tick(); tick(); tick();
        check("rst_stallreq", 32'(bus.stallreq_o), 32'd0);
        check("rst_mem_data", bus.mem_data_o, 32'd0);
        check("rst_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
        check("rst_be_n", 32'(ram_be_n), 32'hF);
        check("rst_addr_oe", {11'd0, ram_data_oe, ram_addr}, 32'd0);
        rst = 1'b1;
        tick();

        // Word read of 0xDEADBEEF at word 0x10
        do_req(1'b0, 4'hF, 32'h40, 32'h0, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
        check("rd_stall", 32'(stall), 32'(READ_WAIT + 1));
        check("rd_oe_cycles", 32'(oe_cyc), 32'(READ_WAIT));
        check("rd_addr", 32'(aseen), 32'h10);
        check("rd_data", bus.mem_data_o, 32'hDEADBEEF);
        end_req();

        // Byte write lane 2 into word 0x20
        do_req(1'b1, 4'b0100, 32'h81, 32'h5A5A5A5A, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
        check("bw_be_n", 32'(beseen), 32'b1011);
        check("bw_we_cycles", 32'(we_cyc), 32'(WRITE_PULSE));
        check("bw_stall", 32'(stall), 32'(WRITE_PULSE + 3));
        check("bw_oe_cycles", 32'(oe_cyc), 32'd0);
        check("bw_sram", sram['h20], 32'h115A3344);
        check("bw_mem_data", bus.mem_data_o, 32'hDEADBEEF);
        ref_mem['h20] = 32'h115A3344;
        end_req();

        // Null write: no SRAM activity, single stall cycle
        do_req(1'b1, 4'b0000, 32'h44, 32'hFFFFFFFF, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
        check("nw_stall", 32'(stall), 32'd1);
        check("nw_ce_cycles", 32'(ce_cyc), 32'd0);
        check("nw_mem_data", bus.mem_data_o, 32'hDEADBEEF);
        end_req();

        // hold_i keeps DONE; ce stays high so a premature IDLE would raise stallreq
        do_req(1'b0, 4'hF, 32'h80, 32'h0, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
        check("hd_data", bus.mem_data_o, 32'h115A3344);
        bus.hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hd_stallreq", 32'(bus.stallreq_o), 32'd0);
            check("hd_data_stable", bus.mem_data_o, 32'h115A3344);
        end
        bus.hold_i = 1'b0;
        bus.mem_addr_i = 32'h4;
        tick();
        check("b2b_idle_stall", 32'(bus.stallreq_o), 32'd1);
        do_req(1'b0, 4'hF, 32'h4, 32'h0, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
        check("b2b_stall", 32'(stall), 32'(READ_WAIT + 1));
        check("b2b_addr", 32'(aseen), 32'h1);
        check("b2b_data", bus.mem_data_o, 32'hCAFEF00D);
        end_req();

        // Reset in the middle of the write pulse
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_sel_i = 4'hF;
        bus.mem_addr_i = 32'h8; bus.mem_data_i = 32'h12345678;
        tick(); tick();
        check("mr_we_low", 32'(ram_we_n), 32'd0);
        rst = 1'b0;
        bus.mem_ce_i = 1'b0;
        tick();
        check("mr_we_n", 32'(ram_we_n), 32'd1);
        check("mr_ce_n", 32'(ram_ce_n), 32'd1);
        check("mr_data_oe", 32'(ram_data_oe), 32'd0);
        check("mr_stallreq", 32'(bus.stallreq_o), 32'd0);
        check("mr_mem_data", bus.mem_data_o, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mr_idle_stallreq", 32'(bus.stallreq_o), 32'd0);
        ref_mem[2] = sram[2];
        do_req(1'b0, 4'hF, 32'h40, 32'h0, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
        check("mr_restart_stall", 32'(stall), 32'(READ_WAIT + 1));
        check("mr_restart_data", bus.mem_data_o, 32'hDEADBEEF);
        last_rd = 32'hDEADBEEF;
        end_req();

        // Random mix with wrapped upper address bits; scoreboard in ref_mem
        for (int n = 0; n < 200; n++) begin
            logic        rwe;
            logic [3:0]  rsel;
            logic [7:0]  widx;
            logic [31:0] rdat;
            logic [31:0] raddr;
            int          exp_stall;
            rwe   = 1'($urandom);
            rsel  = 4'($urandom);
            widx  = 8'($urandom);
            rdat  = $urandom;
            raddr = {10'($urandom), 12'd0, widx, 2'($urandom)};
            do_req(rwe, rsel, raddr, rdat, stall, oe_cyc, we_cyc, ce_cyc, aseen, beseen);
            if (!rwe)             exp_stall = READ_WAIT + 1;
            else if (rsel != '0)  exp_stall = WRITE_PULSE + 3;
            else                  exp_stall = 1;
            check("rnd_stall", 32'(stall), 32'(exp_stall));
            if (!rwe) begin
                last_rd = ref_mem[widx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (rsel[b]) ref_mem[widx][8*b +: 8] = rdat[8*b +: 8];
            end
            check("rnd_mem_data", bus.mem_data_o, last_rd);
            end_req();
        end

        check("contention", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Responder end of the memory-stage data port: accepts the `mem_ce`/`mem_we`/`mem_sel`/`mem_addr`/`mem_data` request and returns the read word.
- Executes each request as a multi-cycle access on an external asynchronous 32-bit SRAM.
- Raises a stall request to the pipeline control block until the access completes.
- Byte lanes follow the memory stage's big-endian mapping: `sel[3]` is data[31:24] and maps to address offset 00.

Parameters:
- `ADDR_W`, 20, SRAM word-address width; the word address is `mem_addr_i[ADDR_W+1:2]`.
- `READ_WAIT`, 2, cycles `oe_n` is held low before read data is sampled (>=1).
- `WRITE_PULSE`, 2, cycles `we_n` is held low (>=1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low: `rst`=0 at a rising edge resets the block.
- `mem_ce_i`  in  1  request valid; held stable by the requester while `stallreq_o`=1.
- `mem_we_i`  in  1  1=write, 0=read.
- `mem_sel_i`  in  4  byte enables, big-endian lane order.
- `mem_addr_i`  in  32  byte address.
- `mem_data_i`  in  32  write data, already lane-replicated by the requester.
- `hold_i`  in  1  pipeline stalled by another source; keeps the completed result presented.
- `mem_data_o`  out  32  read word, valid in state DONE.
- `stallreq_o`  out  1  stall request to pipeline control.
- `ram_addr_o`  out  `ADDR_W`  SRAM word address.
- `ram_data_o`  out  32  SRAM write data.
- `ram_data_oe_o`  out  1  tristate enable for `ram_data_o`.
- `ram_data_i`  in  32  SRAM read data.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1 each  SRAM strobes, active-low.
- `ram_be_n_o`  out  4  SRAM byte enables, active-low.

Behaviour:
- **States:** IDLE, READ, WSETUP, WPULSE, WHOLD, DONE. A wait counter `cnt` of width clog2(max(`READ_WAIT`, `WRITE_PULSE`))+1 is shared by the timed states.
- **Reset** (`rst`=0 at the edge): state=IDLE, `cnt`=0.
  - `mem_data_o`=0, `stallreq_o`=0.
  - `ram_ce_n`/`oe_n`/`we_n`=1, `be_n`=4'b1111.
  - `ram_addr`=0, `ram_data_o`=0, `oe`=0.
  - Reset mid-access aborts immediately. Strobes are deasserted in the cycle after the reset edge; no completion is signalled.
- **stallreq_o** (combinational) = (state==IDLE & `mem_ce_i`) | state in {READ, WSETUP, WPULSE, WHOLD}. It is 0 in DONE.
- **IDLE:** strobes inactive.
  - `mem_ce_i`=1 latches addr, sel, data and we.
  - `we`=0 -> READ with `cnt`=0.
  - `we`=1 and sel!=0 -> WSETUP.
  - `we`=1 and sel==0 -> DONE with no SRAM activity.
- **READ:** `ce_n`=0, `oe_n`=0, `be_n`=0000 (full word always read; lane extraction is done by the requester). `cnt`++ each cycle. When `cnt`==`READ_WAIT`-1: register `ram_data_i` into `mem_data_o`, go to DONE.
- **WSETUP** (1 cycle): `ce_n`=0, `we_n`=1, `oe_n`=1, `be_n`=~sel, addr/data driven, `oe`=1.
- **WPULSE** (`WRITE_PULSE` cycles): as WSETUP but `we_n`=0.
- **WHOLD** (1 cycle): `we_n`=1, addr/data/be still driven -> DONE.
- **DONE:** strobes inactive, `oe`=0, `mem_data_o` held.
  - `hold_i`=1 -> stay in DONE.
  - Otherwise -> IDLE. The request seen in the following cycle is treated as new.
- **Latency:** the request is first seen in IDLE at cycle T.
  - Read: DONE at T+1+`READ_WAIT`; stall for `READ_WAIT`+1 cycles.
  - Write: DONE at T+3+`WRITE_PULSE`.
- **Output stability:** `mem_data_o` changes only on a READ completion or on reset. Writes leave it unchanged.
- **Address wrap:** bits above `ADDR_W`+1 and `addr[1:0]` are ignored. Alignment is the requester's responsibility.
- **Bus contention:** `oe_n`=0 and `ram_data_oe_o`=1 are never asserted in the same cycle.

Decomposition:
- Shared defines file holds:
  - state encodings (`SramIdle`..`SramDone`);
  - `ChipEnable`/`ChipDisable` and `WriteEnable`/`WriteDisable` reuse;
  - the active-low reset level `RstEnableN`=1'b0.
- One natural sub-module, `sram_wait_counter`: a loadable down/up counter with a terminal flag, shared by the READ and WPULSE states. Otherwise the block is a single FSM.

Test Plan:
- **Reset:** `rst`=0 for 2 cycles mid-WPULSE -> next cycle `we_n`=1, `ce_n`=1, `stallreq`=0, `mem_data_o`=0, state IDLE.
- **Word read:** SRAM model holds 0xDEADBEEF at word 0x00010; `ce`=1, `we`=0, addr=0x00000040, `READ_WAIT`=2 -> `stallreq` high 3 cycles; `oe_n` low exactly 2 cycles with `ram_addr`=0x00010; `mem_data_o`=0xDEADBEEF in DONE.
- **Byte write:** sel=4'b0100, data=0x5A5A5A5A, addr=0x00000081; SRAM preloaded 0x11223344 -> `be_n`=4'b1011; `we_n` low 2 cycles; word 0x00020 becomes 0x115A3344; `mem_data_o` unchanged.
- **Null write:** `we`=1, sel=4'b0000 -> DONE next cycle; `ce_n` never asserted; `stallreq` high 1 cycle.
- **hold_i in DONE:** `hold_i`=1 for 3 cycles after a read -> DONE held, `stallreq`=0, `mem_data_o` stable. On release, back-to-back request at addr 0x4 -> new read starts in the following IDLE cycle.
- **Contention check:** random read/write mix of 200 requests -> `oe_n`=0 never coincides with `ram_data_oe_o`=1, and `we_n`=0 never occurs with `oe_n`=0.
